tetris_row_scan: RTL and testbench

- Display-side consumer of the tetris core's 200-bit board vector (`blocks`, 10 columns x 20 rows).
- On Start, it snapshots the board, then scans it one row at a time onto a row-multiplexed LED/segment matrix.
- Each row is held for a fixed dwell and followed by a blanking gap.
- It also counts completely filled rows and reports the count, via a Start/Ack handshake, for scoring/debug logic.

---
 rtl/tetris_pkg.sv | 20 ++
 rtl/row_full_detect.sv | 11 +
 rtl/tetris_row_scan.sv | 123 ++++++++++++
 tb/tb_tetris_row_scan.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared board geometry, scan-state encoding and cell index helper
// for the tetris core and its display-side consumers.
package tetris_pkg;

    localparam int COLS = 10;
    localparam int ROWS = 20;

    typedef logic [4:0] state_t;

    localparam state_t S_I     = 5'b00001;
    localparam state_t S_LOAD  = 5'b00010;
    localparam state_t S_SCAN  = 5'b00100;
    localparam state_t S_BLANK = 5'b01000;
    localparam state_t S_DONE  = 5'b10000;

    function automatic int blk_idx(input int r, input int c);
        return r * COLS + c;
    endfunction

endpackage

// File: rtl/row_full_detect.sv
// Flags a board row whose cells are all occupied.
module row_full_detect #(
    parameter int W = 10
) (
    input  logic [W-1:0] i_row,
    output logic         o_full
);

    assign o_full = &i_row;

endmodule

// File: rtl/tetris_row_scan.sv
// Snapshots the board and scans it row by row onto a multiplexed matrix,
// counting completely filled rows along the way.
module tetris_row_scan
    import tetris_pkg::*;
#(
    parameter int ROW_CYCLES   = 4,
    parameter int BLANK_CYCLES = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Ack,
    input  logic [COLS*ROWS-1:0] blocks,
    output logic [ROWS-1:0]      row_sel,
    output logic [COLS-1:0]      col_data,
    output logic [4:0]           full_rows,
    output logic                 q_I,
    output logic                 q_Load,
    output logic                 q_Scan,
    output logic                 q_Blank,
    output logic                 q_Done
);

    localparam int MAXC = (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] ROW_LAST = CW'(ROW_CYCLES - 1);
    localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [4:0]    ROW_END  = 5'(ROWS - 1);

    state_t               r_state;
    logic [4:0]           r_row;
    logic [CW-1:0]        r_cnt;
    logic [COLS*ROWS-1:0] r_snap;
    logic [ROWS-1:0]      r_row_sel;
    logic [COLS-1:0]      r_col;
    logic [4:0]           r_full;

    state_t               w_state_nxt;
    logic [4:0]           w_row_nxt;
    logic [CW-1:0]        w_cnt_nxt;
    logic [COLS*ROWS-1:0] w_snap_nxt;
    logic [COLS-1:0]      w_row_bits;
    logic                 w_row_full;
    logic [ROWS-1:0]      w_row_sel_nxt;
    logic [COLS-1:0]      w_col_nxt;
    logic [4:0]           w_full_nxt;

    row_full_detect #(.W(COLS)) u_full (
        .i_row  (w_row_bits),
        .o_full (w_row_full)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state   <= S_I;
            r_row     <= '0;
            r_cnt     <= '0;
            r_snap    <= '0;
            r_row_sel <= '0;
            r_col     <= '0;
            r_full    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_row     <= w_row_nxt;
            r_cnt     <= w_cnt_nxt;
            r_snap    <= w_snap_nxt;
            r_row_sel <= w_row_sel_nxt;
            r_col     <= w_col_nxt;
            r_full    <= w_full_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_I:     if (Start) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_SCAN;
            S_SCAN:  if (r_cnt == ROW_LAST) w_state_nxt = S_BLANK;
            S_BLANK: if (r_cnt == BLK_LAST)
                         w_state_nxt = (r_row == ROW_END) ? S_DONE : S_SCAN;
            S_DONE:  if (Ack) w_state_nxt = S_I;
            default: w_state_nxt = S_I;
        endcase
    end

    // Outputs are computed from the next state so they register in step with it
    always_comb begin
        w_row_nxt = r_row;
        if (r_state == S_LOAD)
            w_row_nxt = '0;
        else if (r_state == S_BLANK && w_state_nxt == S_SCAN)
            w_row_nxt = r_row + 5'd1;

        w_cnt_nxt = '0;
        if (w_state_nxt == r_state && (r_state == S_SCAN || r_state == S_BLANK))
            w_cnt_nxt = r_cnt + 1'b1;

        w_snap_nxt = (r_state == S_LOAD) ? blocks : r_snap;
        w_row_bits = w_snap_nxt[blk_idx(int'(w_row_nxt), 0) +: COLS];

        w_row_sel_nxt = '0;
        w_col_nxt     = '0;
        if (w_state_nxt == S_SCAN) begin
            w_row_sel_nxt = ROWS'(1) << w_row_nxt;
            w_col_nxt     = w_row_bits;
        end

        w_full_nxt = (r_state == S_LOAD) ? 5'd0 : r_full;
        if (w_state_nxt == S_SCAN && r_state != S_SCAN && w_row_full)
            w_full_nxt = w_full_nxt + 5'd1;
    end

    assign row_sel   = r_row_sel;
    assign col_data  = r_col;
    assign full_rows = r_full;
    assign q_I       = r_state[0];
    assign q_Load    = r_state[1];
    assign q_Scan    = r_state[2];
    assign q_Blank   = r_state[3];
    assign q_Done    = r_state[4];

endmodule

// File: tb/tb_tetris_row_scan.sv
// Directed bench for tetris_row_scan: frame timing, snapshot, full-row
// count, ignored inputs and mid-frame reset.
module tb_tetris_row_scan;
    import tetris_pkg::*;

    logic                 Clk = 1'b0;
    logic                 Reset;
    logic                 Start;
    logic                 Ack;
    logic [COLS*ROWS-1:0] blocks;
    logic [ROWS-1:0]      row_sel;
    logic [COLS-1:0]      col_data;
    logic [4:0]           full_rows;
    logic                 q_I, q_Load, q_Scan, q_Blank, q_Done;

    int                   n_chk = 0;
    int                   n_err = 0;
    logic [COLS*ROWS-1:0] exp_snap;

    always #5 Clk = ~Clk;

    tetris_row_scan dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Ack       (Ack),
        .blocks    (blocks),
        .row_sel   (row_sel),
        .col_data  (col_data),
        .full_rows (full_rows),
        .q_I       (q_I),
        .q_Load    (q_Load),
        .q_Scan    (q_Scan),
        .q_Blank   (q_Blank),
        .q_Done    (q_Done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic start_frame(input logic with_ack);
        exp_snap = blocks;
        Start = 1'b1;
        Ack   = with_ack;
        tick;
        chk("load_q", {q_Done, q_Blank, q_Scan, q_Load, q_I}, 5'b00010);
        Start = 1'b0;
        Ack   = 1'b0;
    endtask

    // pert: Start pulse in row 3, blocks cleared in row 5, Ack pulse in Blank of row 7
    task automatic run_frame(input logic pert, input int stop_row, input logic [4:0] exp_full);
        logic [ROWS-1:0] e_sel;
        for (int r = 0; r < ROWS; r++) begin
            e_sel = ROWS'(1) << r;
            for (int k = 0; k < 4; k++) begin
                tick;
                chk("scan_q", {q_Done, q_Blank, q_Scan, q_Load, q_I}, 5'b00100);
                chk("scan_sel", row_sel, e_sel);
                chk("scan_col", col_data, exp_snap[r*COLS +: COLS]);
                Ack   = 1'b0;
                Start = pert && r == 3 && k == 0;
                if (pert && r == 5 && k == 0) blocks = '0;
                if (r == stop_row && k == 1) return;
            end
            tick;
            chk("blank_q", {q_Done, q_Blank, q_Scan, q_Load, q_I}, 5'b01000);
            chk("blank_sel", row_sel, 0);
            chk("blank_col", col_data, 0);
            Ack = pert && r == 7;
        end
        tick;
        chk("done_q", {q_Done, q_Blank, q_Scan, q_Load, q_I}, 5'b10000);
        chk("done_sel", row_sel, 0);
        chk("done_full", full_rows, exp_full);
    endtask

    initial begin
        Reset  = 1'b0;
        Start  = 1'b0;
        Ack    = 1'b0;
        blocks = '0;
        tick;
        tick;
        Reset = 1'b1;
        tick;
        chk("rst_q", {q_Done, q_Blank, q_Scan, q_Load, q_I}, 5'b00001);
        chk("rst_sel", row_sel, 0);
        chk("rst_col", col_data, 0);
        chk("rst_full", full_rows, 0);
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("idle_q", {q_Done, q_Blank, q_Scan, q_Load, q_I}, 5'b00001);
        end

        // empty board
        start_frame(1'b0);
        run_frame(1'b0, -1, 5'd0);
        Ack = 1'b1;
        tick;
        chk("ack1_q", {q_Done, q_Blank, q_Scan, q_Load, q_I}, 5'b00001);
        Ack = 1'b0;

        // rows 18/19 full, row 0 = 0x201
        blocks = '0;
        blocks[9:0] = 10'h201;
        blocks[199:180] = '1;
        start_frame(1'b0);
        run_frame(1'b0, -1, 5'd2);
        Ack = 1'b1;
        tick;
        chk("ack2_q", {q_Done, q_Blank, q_Scan, q_Load, q_I}, 5'b00001);
        chk("ack2_full", full_rows, 2);
        Ack = 1'b0;

        // full board, Start+Ack together, perturbations mid-frame
        blocks = '1;
        start_frame(1'b1);
        run_frame(1'b1, -1, 5'd20);
        for (int i = 0; i < 20; i++) begin
            tick;
            chk("hold_q", {q_Done, q_Blank, q_Scan, q_Load, q_I}, 5'b10000);
            chk("hold_full", full_rows, 20);
        end
        Ack = 1'b1;
        tick;
        chk("ack3_q", {q_Done, q_Blank, q_Scan, q_Load, q_I}, 5'b00001);
        Ack = 1'b0;

        // reset mid-frame at row 10
        blocks = '0;
        blocks[49:0] = '1;
        start_frame(1'b0);
        run_frame(1'b0, 10, 5'd0);
        chk("mid_full", full_rows, 5);
        Reset = 1'b0;
        tick;
        chk("mrst_q", {q_Done, q_Blank, q_Scan, q_Load, q_I}, 5'b00001);
        chk("mrst_sel", row_sel, 0);
        chk("mrst_col", col_data, 0);
        chk("mrst_full", full_rows, 0);
        Reset = 1'b1;
        tick;
        start_frame(1'b0);
        run_frame(1'b0, -1, 5'd5);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
